// File: rtl/muxer_pkg.sv
// Shared defaults and select-width helper for the muxer block.
package muxer_pkg;

  localparam int unsigned MUXER_N_IN_DEF   = 8;
  localparam int unsigned MUXER_DATA_W_DEF = 1;

  // Select width for n lanes, never narrower than one bit.
  function automatic int unsigned muxer_sel_w(input int unsigned n);
    return (n < 2) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/muxer_decode.sv
// SEL_W-to-N_OUT one-hot decoder; indices at or beyond N_OUT decode to all zeros.
module muxer_decode #(
  parameter int unsigned N_OUT = 8,
  parameter int unsigned SEL_W = 3
) (
  input  logic [SEL_W-1:0] sel_i,
  output logic [N_OUT-1:0] oh_o
);

  // Equality compare keeps an unknown select unknown rather than picking a lane.
  always_comb begin
    oh_o = '0;
    for (int k = 0; k < int'(N_OUT); k++) begin
      oh_o[k] = (sel_i == SEL_W'(k));
    end
  end

endmodule

// File: rtl/muxer.sv
// N-to-1 lane multiplexer with combinational q and registered q_r.
// Define MUXER_ONEHOT_EN to expose sel_oh and build q as an AND-OR tree.
module muxer
  import muxer_pkg::*;
#(
  parameter  int unsigned N_IN   = MUXER_N_IN_DEF,
  parameter  int unsigned DATA_W = MUXER_DATA_W_DEF,
  localparam int unsigned SEL_W  = muxer_sel_w(N_IN)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_IN*DATA_W-1:0]   in,
  input  logic [SEL_W-1:0]         sel,
  output logic [DATA_W-1:0]        q,
  output logic [DATA_W-1:0]        q_r
`ifdef MUXER_ONEHOT_EN
  ,
  output logic [N_IN-1:0]          sel_oh
`endif
);

  logic [DATA_W-1:0] q_r_d;
  logic [DATA_W-1:0] q_r_q;

`ifdef MUXER_ONEHOT_EN
  logic [DATA_W-1:0] lane [N_IN];

  for (genvar k = 0; k < int'(N_IN); k++) begin : g_lane
    assign lane[k] = in[k*DATA_W +: DATA_W];
  end

  muxer_decode #(
    .N_OUT (N_IN),
    .SEL_W (SEL_W)
  ) u_decode (
    .sel_i (sel),
    .oh_o  (sel_oh)
  );

  always_comb begin
    q = '0;
    for (int k = 0; k < int'(N_IN); k++) begin
      q = q | (lane[k] & {DATA_W{sel_oh[k]}});
    end
  end
`else
  // Pad the lane table to the full select range so out-of-range indices read zero.
  localparam int unsigned N_PAD = 32'd1 << SEL_W;

  logic [DATA_W-1:0] lane [N_PAD];

  for (genvar k = 0; k < int'(N_PAD); k++) begin : g_lane
    if (k < int'(N_IN)) begin : g_real
      assign lane[k] = in[k*DATA_W +: DATA_W];
    end else begin : g_pad
      assign lane[k] = '0;
    end
  end

  assign q = lane[sel];
`endif

  assign q_r_d = q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r_q <= '0;
    end else begin
      q_r_q <= q_r_d;
    end
  end

  assign q_r = q_r_q;

endmodule

// File: tb/tb_muxer.sv
// Randomized bench for muxer: default 8x1 instance plus a 5x4 non-power-of-2 instance.
module tb_muxer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in8;
  logic [2:0]  sel8;
  logic        q8;
  logic        qr8;
  logic [19:0] in5;
  logic [2:0]  sel5;
  logic [3:0]  q5;
  logic [3:0]  qr5;
`ifdef MUXER_ONEHOT_EN
  logic [7:0]  oh8;
  logic [4:0]  oh5;
`endif

  int checks   = 0;
  int failures = 0;

  logic [3:0] exp_qr8 = '0;
  logic [3:0] exp_qr5 = '0;

  always #5 clk = ~clk;

  muxer u_dut8 (
    .clk    (clk),
    .rst    (rst),
    .in     (in8),
    .sel    (sel8),
    .q      (q8),
    .q_r    (qr8)
`ifdef MUXER_ONEHOT_EN
    ,
    .sel_oh (oh8)
`endif
  );

  muxer #(
    .N_IN   (5),
    .DATA_W (4)
  ) u_dut5 (
    .clk    (clk),
    .rst    (rst),
    .in     (in5),
    .sel    (sel5),
    .q      (q5),
    .q_r    (qr5)
`ifdef MUXER_ONEHOT_EN
    ,
    .sel_oh (oh5)
`endif
  );

  // Reference: lane s of an n-lane, w-bit packed word, zero when s is out of range.
  function automatic logic [3:0] ref_lane(input logic [31:0] v, input int n, input int w,
                                          input int s);
    logic [31:0] mask;
    if (s >= n) return 4'h0;
    mask = (32'd1 << w) - 32'd1;
    return 4'((v >> (s * w)) & mask);
  endfunction

  function automatic logic [31:0] ref_oh(input int n, input int s);
    return (s < n) ? (32'd1 << s) : 32'd0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Registered expectation: value of the selected lane at each clock edge, zero under reset.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_qr8 = '0;
      exp_qr5 = '0;
    end else begin
      exp_qr8 = ref_lane({24'd0, in8}, 8, 1, int'(sel8));
      exp_qr5 = ref_lane({12'd0, in5}, 5, 4, int'(sel5));
    end
  end

  // Compare every output against the model on every falling edge.
  always @(negedge clk) begin
    check("q8",  {31'd0, q8},  {28'd0, ref_lane({24'd0, in8}, 8, 1, int'(sel8))});
    check("qr8", {31'd0, qr8}, {28'd0, exp_qr8});
    check("q5",  {28'd0, q5},  {28'd0, ref_lane({12'd0, in5}, 5, 4, int'(sel5))});
    check("qr5", {28'd0, qr5}, {28'd0, exp_qr5});
`ifdef MUXER_ONEHOT_EN
    check("oh8", {24'd0, oh8}, ref_oh(8, int'(sel8)));
    check("oh5", {27'd0, oh5}, ref_oh(5, int'(sel5)));
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst  = 1'b1;
    in8  = '0;
    sel8 = '0;
    in5  = '0;
    sel5 = '0;
    #1;
    check("reset_qr8", {31'd0, qr8}, 32'd0);
    check("reset_qr5", {28'd0, qr5}, 32'd0);
    in8  = 8'b00001000;
    sel8 = 3'b011;
    #1;
    check("q_during_reset", {31'd0, q8}, 32'd1);
    @(negedge clk);
    #2 rst = 1'b0;

    // Walking one and walking zero on the default instance.
    for (int k = 0; k < 8; k++) begin
      step();
      sel8 = 3'(k);
      in8  = 8'(8'd1 << k);
      #1 check("walk_one", {31'd0, q8}, 32'd1);
    end
    for (int k = 0; k < 8; k++) begin
      step();
      sel8 = 3'(k);
      in8  = ~8'(8'd1 << k);
      #1 check("walk_zero", {31'd0, q8}, 32'd0);
    end

    // Registered path.
    step();
    sel8 = 3'b111;
    in8  = 8'b10000000;
    step();
    check("qr_load", {31'd0, qr8}, 32'd1);
    in8 = 8'b01111111;
    #1;
    check("q_fall", {31'd0, q8}, 32'd0);
    check("qr_hold", {31'd0, qr8}, 32'd1);
    step();
    check("qr_fall", {31'd0, qr8}, 32'd0);

    // Asynchronous reset between edges.
    in8 = 8'b10000000;
    step();
    check("qr_before_rst", {31'd0, qr8}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("qr_async_rst", {31'd0, qr8}, 32'd0);
    check("q_in_rst", {31'd0, q8}, 32'd1);
    #3 rst = 1'b0;
    step();
    check("qr_after_rst", {31'd0, qr8}, 32'd1);

    // Non-power-of-2 instance boundaries.
    sel5 = 3'd6;
    in5  = 20'($urandom);
    #1 check("q5_oor", {28'd0, q5}, 32'd0);
    sel5 = 3'd4;
    in5  = {4'hA, 16'($urandom)};
    #1 check("q5_lane4", {28'd0, q5}, 32'h0000000A);

`ifdef MUXER_ONEHOT_EN
    sel8 = 3'b010;
    #1 check("oh8_lit", {24'd0, oh8}, 32'h00000004);
    sel5 = 3'd7;
    #1 check("oh5_oor", {27'd0, oh5}, 32'd0);
`endif

    // Random traffic with occasional mid-cycle reset pulses.
    for (int i = 0; i < 400; i++) begin
      step();
      in8  = 8'($urandom);
      sel8 = 3'($urandom);
      in5  = 20'($urandom);
      sel5 = 3'($urandom);
      if ($urandom_range(0, 31) == 0) begin
        #2 rst = 1'b1;
        #4 rst = 1'b0;
      end
    end

    step();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
